// File: rtl/cmul_accumulator.sv
// Block accumulator for complex products: sums N signed Pr/Pi products and hands the sum over valid/ready.
// Optional macro CMAC_SAT_EN clamps overflowing sums instead of wrapping.
module cmul_accumulator #(
  parameter int unsigned DW = 24,
  parameter int unsigned AW = 32,
  parameter int unsigned N  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] Pr,
  input  logic signed [DW-1:0] Pi,
  input  logic                 flush,
  output logic signed [AW-1:0] acc_r,
  output logic signed [AW-1:0] acc_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           count,
  output logic                 ovf
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] N_LAST = CW'(N);
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_r_q, acc_r_d;
  logic signed [AW-1:0]  acc_i_q, acc_i_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic                  accept_c;
  logic signed [AW-1:0]  base_r_c, base_i_c;
  logic [AW:0]           sum_r_c, sum_i_c;
  logic [CW-1:0]         count_inc_c;

  // Returns {overflow, sum}; an overflowing sum wraps or clamps depending on the build.
  function automatic logic [AW:0] add_chk(input logic signed [AW-1:0] a,
                                          input logic signed [AW-1:0] b);
    logic signed [AW-1:0] s;
    logic                 o;
    s = a + b;
    o = (a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1]);
`ifdef CMAC_SAT_EN
    if (o) s = a[AW-1] ? ACC_MIN : ACC_MAX;
`endif
    return {o, s};
  endfunction

  always_comb begin
    accept_c    = in_valid && in_ready_q;
    base_r_c    = (state_q == S_IDLE) ? '0 : acc_r_q;
    base_i_c    = (state_q == S_IDLE) ? '0 : acc_i_q;
    sum_r_c     = add_chk(base_r_c, AW'(Pr));
    sum_i_c     = add_chk(base_i_c, AW'(Pi));
    count_inc_c = (state_q == S_IDLE) ? CW'(1) : count_q + CW'(1);
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept_c) begin
          acc_r_d = sum_r_c[AW-1:0];
          acc_i_d = sum_i_c[AW-1:0];
          count_d = count_inc_c;
          ovf_d   = ovf_q | sum_r_c[AW] | sum_i_c[AW];
          state_d = (count_inc_c == N_LAST || flush) ? S_HOLD : S_ACCUM;
        end else if (flush && state_q == S_ACCUM) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_r_d = '0;
          acc_i_d = '0;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_HOLD);
    in_ready_d  = (state_d != S_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_r_q     <= '0;
      acc_i_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_r_q     <= acc_r_d;
      acc_i_q     <= acc_i_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign acc_r     = acc_r_q;
  assign acc_i     = acc_i_q;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_cmul_accumulator.sv
// Directed bench for cmul_accumulator: default N=8 instance, AW=24/N=2 overflow instance, N=1 instance.
module tb_cmul_accumulator;

  logic clk;
  logic rst;

  logic               in_valid_a, flush_a, out_ready_a, in_ready_a, out_valid_a, ovf_a;
  logic signed [23:0] pr_a, pi_a;
  logic signed [31:0] acc_r_a, acc_i_a;
  logic [7:0]         count_a;

  logic               in_valid_b, flush_b, out_ready_b, in_ready_b, out_valid_b, ovf_b;
  logic signed [23:0] pr_b, pi_b;
  logic [23:0]        acc_r_b, acc_i_b;
  logic [7:0]         count_b;

  logic               in_valid_c, flush_c, out_ready_c, in_ready_c, out_valid_c, ovf_c;
  logic signed [23:0] pr_c, pi_c;
  logic signed [31:0] acc_r_c, acc_i_c;
  logic [7:0]         count_c;

  int n_checks;
  int n_fail;
  logic idle_m;

  cmul_accumulator dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .Pr(pr_a), .Pi(pi_a), .flush(flush_a), .acc_r(acc_r_a), .acc_i(acc_i_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .count(count_a), .ovf(ovf_a)
  );

  cmul_accumulator #(.DW(24), .AW(24), .N(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .Pr(pr_b), .Pi(pi_b), .flush(flush_b), .acc_r(acc_r_b), .acc_i(acc_i_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .count(count_b), .ovf(ovf_b)
  );

  cmul_accumulator #(.N(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .Pr(pr_c), .Pi(pi_c), .flush(flush_c), .acc_r(acc_r_c), .acc_i(acc_i_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .count(count_c), .ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    {in_valid_a, flush_a, out_ready_a} = '0; pr_a = '0; pi_a = '0;
    {in_valid_b, flush_b, out_ready_b} = '0; pr_b = '0; pi_b = '0;
    {in_valid_c, flush_c, out_ready_c} = '0; pr_c = '0; pi_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", 32'(in_ready_a), 1);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_acc_r", acc_r_a, 0);
    chk("rst_acc_i", acc_i_a, 0);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);

    // Basic sum: Pr=i, Pi=-i for i=1..8
    out_ready_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_a = 1'b1; pr_a = 24'(i); pi_a = 24'(-i);
      tick();
      if (i == 7) chk("basic_not_done", 32'(out_valid_a), 0);
    end
    in_valid_a = 1'b0;
    chk("basic_valid", 32'(out_valid_a), 1);
    chk("basic_acc_r", acc_r_a, 36);
    chk("basic_acc_i", acc_i_a, -36);
    chk("basic_count", 32'(count_a), 8);
    chk("basic_hold_ready", 32'(in_ready_a), 0);
    tick();
    chk("basic_idle_valid", 32'(out_valid_a), 0);
    chk("basic_idle_count", 32'(count_a), 0);
    chk("basic_idle_acc", acc_r_a, 0);
    chk("basic_idle_ready", 32'(in_ready_a), 1);

    // Backpressure: sum of eight (2,3) held for 5 cycles with in_valid high
    out_ready_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1; pr_a = 24'sd2; pi_a = 24'sd3;
      tick();
    end
    pr_a = 24'sd1000; pi_a = '0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 32'(in_ready_a), 0);
      chk("bp_valid", 32'(out_valid_a), 1);
      chk("bp_acc_r", acc_r_a, 16);
      chk("bp_acc_i", acc_i_a, 24);
      tick();
    end
    out_ready_a = 1'b1;
    tick();
    chk("bp_release_ready", 32'(in_ready_a), 1);
    chk("bp_release_valid", 32'(out_valid_a), 0);
    chk("bp_release_count", 32'(count_a), 0);
    out_ready_a = 1'b0;
    tick();
    chk("bp_next_count", 32'(count_a), 1);
    chk("bp_next_acc", acc_r_a, 1000);
    in_valid_a = 1'b0; flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    chk("flush_accum_valid", 32'(out_valid_a), 1);
    chk("flush_accum_acc", acc_r_a, 1000);
    chk("flush_accum_count", 32'(count_a), 1);
    out_ready_a = 1'b1;
    tick();

    // Early flush coincident with the 3rd product
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; pi_a = '0;
    pr_a = 24'sd100; tick();
    pr_a = 24'sd200; tick();
    pr_a = 24'sd300; flush_a = 1'b1; tick();
    flush_a = 1'b0; in_valid_a = 1'b0;
    chk("eflush_valid", 32'(out_valid_a), 1);
    chk("eflush_acc_r", acc_r_a, 600);
    chk("eflush_acc_i", acc_i_a, 0);
    chk("eflush_count", 32'(count_a), 3);
    out_ready_a = 1'b1;
    tick();
    chk("eflush_drain", 32'(out_valid_a), 0);

    // Flush in IDLE without a product: ignored
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    chk("idle_flush_valid", 32'(out_valid_a), 0);
    chk("idle_flush_ready", 32'(in_ready_a), 1);
    chk("idle_flush_count", 32'(count_a), 0);
    tick();
    chk("idle_flush_valid2", 32'(out_valid_a), 0);

    // Flush in IDLE with a product: one-product block
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; pr_a = -24'sd5; pi_a = 24'sd4; flush_a = 1'b1;
    tick();
    in_valid_a = 1'b0; flush_a = 1'b0;
    chk("idle_flush_acc_valid", 32'(out_valid_a), 1);
    chk("idle_flush_acc_r", acc_r_a, -5);
    chk("idle_flush_acc_i", acc_i_a, 4);
    chk("idle_flush_acc_count", 32'(count_a), 1);
    out_ready_a = 1'b1;
    tick();

    // Asynchronous reset mid-block
    for (int i = 0; i < 4; i++) begin
      in_valid_a = 1'b1; pr_a = 24'sd7; pi_a = '0;
      tick();
    end
    in_valid_a = 1'b0;
    chk("mid_acc_before", acc_r_a, 28);
    chk("mid_count_before", 32'(count_a), 4);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_acc", acc_r_a, 0);
    chk("mid_rst_count", 32'(count_a), 0);
    chk("mid_rst_valid", 32'(out_valid_a), 0);
    chk("mid_rst_ready", 32'(in_ready_a), 1);
    #2 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1; pr_a = 24'sd1; pi_a = '0;
      tick();
    end
    in_valid_a = 1'b0;
    chk("post_rst_valid", 32'(out_valid_a), 1);
    chk("post_rst_acc", acc_r_a, 8);
    chk("post_rst_count", 32'(count_a), 8);
    tick();
    chk("main_no_ovf", 32'(ovf_a), 0);

    // Overflow: AW=24, N=2, positive then negative extremes
    out_ready_b = 1'b0;
    in_valid_b = 1'b1; pr_b = 24'sh7FFFFF; pi_b = '0;
    tick();
    chk("ovf_first_flag", 32'(ovf_b), 0);
    chk("ovf_first_acc", 32'(acc_r_b), 32'h7FFFFF);
    tick();
    in_valid_b = 1'b0;
    chk("ovf_pos_valid", 32'(out_valid_b), 1);
`ifdef CMAC_SAT_EN
    chk("ovf_pos_acc", 32'(acc_r_b), 32'h7FFFFF);
`else
    chk("ovf_pos_acc", 32'(acc_r_b), 32'hFFFFFE);
`endif
    chk("ovf_pos_flag", 32'(ovf_b), 1);
    out_ready_b = 1'b1;
    tick();
    chk("ovf_sticky", 32'(ovf_b), 1);
    chk("ovf_drain_valid", 32'(out_valid_b), 0);
    out_ready_b = 1'b0;
    in_valid_b = 1'b1; pr_b = 24'sh800000;
    tick();
    tick();
    in_valid_b = 1'b0;
`ifdef CMAC_SAT_EN
    chk("ovf_neg_acc", 32'(acc_r_b), 32'h800000);
`else
    chk("ovf_neg_acc", 32'(acc_r_b), 0);
`endif
    chk("ovf_neg_flag", 32'(ovf_b), 1);

    // N=1: one product every two cycles under continuous valid/ready
    chk("n1_ready_start", 32'(in_ready_c), 1);
    out_ready_c = 1'b1;
    in_valid_c  = 1'b1;
    idle_m = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      pr_c = 24'(k * 10); pi_c = 24'(-k);
      tick();
      if (idle_m) begin
        chk("n1_valid", 32'(out_valid_c), 1);
        chk("n1_acc_r", acc_r_c, k * 10);
        chk("n1_acc_i", acc_i_c, -k);
        chk("n1_count", 32'(count_c), 1);
      end else begin
        chk("n1_gap_valid", 32'(out_valid_c), 0);
        chk("n1_gap_ready", 32'(in_ready_c), 1);
      end
      idle_m = !idle_m;
    end
    in_valid_c = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmul_accumulator.md
Name: cmul_accumulator

Overview:
- Downstream stage of the 12x12 complex multiplier top.
- Consumes signed 24-bit products Pr/Pi and sums a block of N consecutive products into wide real/imag accumulators, i.e. a complex dot product.
- Presents the finished sum with a valid/ready handshake and applies backpressure to the product source while a result is unclaimed.

Parameters:
- DW, 24, width of the signed Pr/Pi inputs.
- AW, 32, width of the signed accumulators and outputs. Must satisfy AW >= DW.
- N, 8, number of products per block. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  Pr/Pi hold a valid product.
- in_ready  output  1  block accepts a product this cycle.
- Pr  input  DW  signed real product.
- Pi  input  DW  signed imaginary product.
- flush  input  1  one-cycle pulse: close the current block early.
- acc_r  output  AW  signed real sum.
- acc_i  output  AW  signed imaginary sum.
- out_valid  output  1  acc_r/acc_i hold a completed block.
- out_ready  input  1  consumer takes the result.
- count  output  8  products accepted in the current block.
- ovf  output  1  sticky overflow flag, real or imag.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; acc_r=0, acc_i=0, count=0, out_valid=0, ovf=0, in_ready=1. Reset mid-block discards the partial sum.
- Accept: a product is taken when in_valid && in_ready, on the rising edge. Pr/Pi are sign-extended to AW before adding.
- States:
  - IDLE: nothing accumulated, in_ready=1. On accept: acc = ext(P), count=1. Go to HOLD if N==1, else ACCUM.
  - ACCUM: in_ready=1. On accept: acc += ext(P), count++. When count reaches N, go to HOLD.
  - HOLD: out_valid=1, in_ready=0, acc frozen. On out_ready: next cycle out_valid=0, acc=0, count=0, go to IDLE.
- Latency: out_valid rises on the cycle after the Nth product is accepted.
- Flush rule:
  - Flush in ACCUM: go to HOLD with the current partial sum. If an accept happens in the same cycle, that product is included first.
  - Flush in IDLE: with a same-cycle accept, go to HOLD with a one-product sum; otherwise ignored, no empty result is emitted.
  - Flush in HOLD: ignored.
- HOLD/IDLE transfer: there is no same-cycle HOLD->ACCUM bypass. A product can be accepted no earlier than the cycle after out_ready is seen.
- Overflow (per component): signed overflow when both addends share a sign and the sum's sign differs. ovf is set sticky, cleared only by reset.
- Data outputs: acc_r/acc_i are visible continuously and are only meaningful while out_valid=1.
- count stays at its final value during HOLD.

Optional Feature:
- Macro: CMAC_SAT_EN.
- Defined: an overflowing sum clamps to the signed extreme of AW bits (+2^(AW-1)-1 or -2^(AW-1)) and ovf is set.
- Undefined: two's-complement wrap and ovf is set.
- All other behaviour is identical either way.

Test Plan:
- Basic sum: N=8, feed Pr=i, Pi=-i for i=1..8, out_ready=1 → out_valid one cycle after the 8th accept, acc_r=36, acc_i=-36, count=8, then IDLE.
- Backpressure: hold out_ready=0 for 5 cycles after completion with in_valid=1 → in_ready=0 throughout, acc frozen. Release → next block accepted starting the cycle after out_ready.
- Early flush: 3 products (100, 200, 300 real; 0 imag), flush coincident with the 3rd → acc_r=600, count=3, out_valid next cycle. Flush pulsed in IDLE with no in_valid → no out_valid.
- Overflow: AW=24, N=2, Pr=0x7FFFFF twice. Without CMAC_SAT_EN → acc_r=0xFFFFFE, ovf=1. With it → acc_r=0x7FFFFF, ovf=1.
- Reset mid-block: accept 4 products, drop rst asynchronously between edges → outputs 0 immediately. After release, 8 products of Pr=1 → acc_r=8.
- N=1 edge: every accept yields out_valid next cycle with acc equal to that single product. Alternating in_ready/out_valid gives one product every two cycles.
